// File: rtl/io_pad_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pad_cond_pkg
// Description : Shared types and default constants for the IO pad
//               conditioner and its synchroniser.
//               Contents:
//                 - filt_state_e : glitch-filter state (STABLE / PENDING)
//                 - SYNC_STAGES_DEF, FILT_W_DEF, GLITCH_W_DEF defaults
// Revision    : 1.0 - initial release
// ============================================================================
package io_pad_cond_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_W_DEF      = 4;
    localparam int GLITCH_W_DEF    = 8;

    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } filt_state_e;

endpackage
`default_nettype wire

// File: rtl/io_pad_cond_sync.sv
`default_nettype none
// ============================================================================
// Module      : io_pad_cond_sync
// Description : N-stage flop synchroniser for an asynchronous 1-bit input.
//               Ports:
//                 clk  - sampling clock (rising edge)
//                 rst  - synchronous active-high reset, clears the chain
//                 i_d  - asynchronous input level
//                 o_q  - synchronised level (last stage of the chain)
//               Parameter STAGES is the chain depth and must be >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module io_pad_cond_sync
    import io_pad_cond_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain_q;
    logic [STAGES-1:0] w_chain_d;

    // Stage 0 captures the raw input; each later stage takes its predecessor.
    always_comb begin
        w_chain_d = {r_chain_q[STAGES-2:0], i_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain_q <= '0;
        end else begin
            r_chain_q <= w_chain_d;
        end
    end

    assign o_q = r_chain_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/io_pad_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : io_pad_conditioner
// Description : Pad-side conditioning between a bidirectional pad and an IO
//               BEL. Input path: synchroniser -> programmable glitch filter
//               -> O_top, with a saturating count of rejected pulses.
//               Output path: one register stage on data and output enable.
//               Ports:
//                 UserCLK    - clock, all logic on rising edge
//                 Reset      - synchronous active-high reset
//                 filt_len   - stable cycles required to accept a change,
//                              0 = bypass (O_top follows synchroniser)
//                 pad_in     - asynchronous pad receiver level
//                 O_top      - conditioned level to the IO BEL
//                 I_top      - output data from the IO BEL
//                 T_top      - output enable from the IO BEL (1 = drive)
//                 pad_out    - registered data to pad driver
//                 pad_oe     - registered output enable (0 = high-Z)
//                 glitch_cnt - saturating count of rejected input pulses
//                 rise_pulse - one-cycle pulse after O_top rises
//                 fall_pulse - one-cycle pulse after O_top falls
//               Build option: define IO_PAD_COND_EDGE_EN to enable the
//               rise/fall pulse generator; otherwise both pulses are tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module io_pad_conditioner
    import io_pad_cond_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_W      = FILT_W_DEF,
    parameter int GLITCH_W    = GLITCH_W_DEF
) (
    input  logic                UserCLK,
    input  logic                Reset,
    input  logic [FILT_W-1:0]   filt_len,
    input  logic                pad_in,
    output logic                O_top,
    input  logic                I_top,
    input  logic                T_top,
    output logic                pad_out,
    output logic                pad_oe,
    output logic [GLITCH_W-1:0] glitch_cnt,
    output logic                rise_pulse,
    output logic                fall_pulse
);

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic w_x;

    io_pad_cond_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (UserCLK),
        .rst (Reset),
        .i_d (pad_in),
        .o_q (w_x)
    );

    // ------------------------------------------------------------------
    // Glitch filter
    // ------------------------------------------------------------------
    filt_state_e         r_state_q,  w_state_d;
    logic                r_s_q,      w_s_d;
    logic [FILT_W-1:0]   r_cnt_q,    w_cnt_d;
    logic [GLITCH_W-1:0] r_glitch_q, w_glitch_d;

    logic                w_bypass;
    logic [FILT_W:0]     w_cnt_inc;
    logic                w_commit;

    assign w_bypass  = (filt_len == '0);
    // One extra bit so C+1 cannot wrap when C is at its maximum.
    assign w_cnt_inc = {1'b0, r_cnt_q} + {{FILT_W{1'b0}}, 1'b1};
    // >= (not ==) so a filt_len lowered below the running count commits at once.
    assign w_commit  = (w_cnt_inc >= {1'b0, filt_len});

    always_comb begin
        w_state_d  = r_state_q;
        w_s_d      = r_s_q;
        w_cnt_d    = r_cnt_q;
        w_glitch_d = r_glitch_q;
        if (w_bypass) begin
            // Track the synchroniser directly; a pending count is dropped silently.
            w_s_d     = w_x;
            w_cnt_d   = '0;
            w_state_d = STABLE;
        end else if (w_x != r_s_q) begin
            if (w_commit) begin
                w_s_d     = w_x;
                w_cnt_d   = '0;
                w_state_d = STABLE;
            end else begin
                // No overflow: not committing means C+1 < filt_len <= max.
                w_cnt_d   = w_cnt_inc[FILT_W-1:0];
                w_state_d = PENDING;
            end
        end else if (r_state_q == PENDING) begin
            // Input fell back before reaching filt_len: a rejected glitch.
            w_cnt_d   = '0;
            w_state_d = STABLE;
            if (r_glitch_q != '1) begin
                w_glitch_d = r_glitch_q + {{(GLITCH_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            r_state_q  <= STABLE;
            r_s_q      <= 1'b0;
            r_cnt_q    <= '0;
            r_glitch_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_s_q      <= w_s_d;
            r_cnt_q    <= w_cnt_d;
            r_glitch_q <= w_glitch_d;
        end
    end

    assign O_top      = w_bypass ? w_x : r_s_q;
    assign glitch_cnt = r_glitch_q;

    // ------------------------------------------------------------------
    // Output path
    // ------------------------------------------------------------------
    logic r_pad_out_q, w_pad_out_d;
    logic r_pad_oe_q,  w_pad_oe_d;

    always_comb begin
        w_pad_out_d = I_top;
        w_pad_oe_d  = T_top;
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            r_pad_out_q <= 1'b0;
            r_pad_oe_q  <= 1'b0;
        end else begin
            r_pad_out_q <= w_pad_out_d;
            r_pad_oe_q  <= w_pad_oe_d;
        end
    end

    assign pad_out = r_pad_out_q;
    assign pad_oe  = r_pad_oe_q;

    // ------------------------------------------------------------------
    // Edge pulses
    // ------------------------------------------------------------------
`ifdef IO_PAD_COND_EDGE_EN
    logic r_o_top_q, w_o_top_d;
    logic r_rise_q,  w_rise_d;
    logic r_fall_q,  w_fall_d;

    // Compare current O_top with its one-cycle-old copy; pulses are
    // registered, so they appear the cycle after O_top changes.
    always_comb begin
        w_o_top_d = O_top;
        w_rise_d  = O_top & ~r_o_top_q;
        w_fall_d  = ~O_top & r_o_top_q;
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            r_o_top_q <= 1'b0;
            r_rise_q  <= 1'b0;
            r_fall_q  <= 1'b0;
        end else begin
            r_o_top_q <= w_o_top_d;
            r_rise_q  <= w_rise_d;
            r_fall_q  <= w_fall_d;
        end
    end

    assign rise_pulse = r_rise_q;
    assign fall_pulse = r_fall_q;
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_pad_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_pad_conditioner
// Description : Self-checking bench for io_pad_conditioner: a vector table,
//               hand-written multi-cycle sequences, and a randomized run
//               against a behavioural reference model. Honors
//               IO_PAD_COND_EDGE_EN for the edge-pulse expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_pad_conditioner;

    localparam int SYNC = 2;
    localparam int GMAX = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fl;
    logic       pad;
    logic       i_top;
    logic       t_top;
    logic       o_top;
    logic       pad_out;
    logic       pad_oe;
    logic [7:0] glitch;
    logic       rise;
    logic       fall;

    io_pad_conditioner #(
        .SYNC_STAGES (SYNC),
        .FILT_W      (4),
        .GLITCH_W    (8)
    ) dut (
        .UserCLK    (clk),
        .Reset      (rst),
        .filt_len   (fl),
        .pad_in     (pad),
        .O_top      (o_top),
        .I_top      (i_top),
        .T_top      (t_top),
        .pad_out    (pad_out),
        .pad_oe     (pad_oe),
        .glitch_cnt (glitch),
        .rise_pulse (rise),
        .fall_pulse (fall)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pad history queue for the synchroniser delay and a
    // run length of consecutive cycles the delayed input differed from the
    // accepted value.
    // ------------------------------------------------------------------
    int m_hist[$];
    int m_s, m_run, m_glitch, m_pout, m_poe, m_od, m_rise, m_fall;

    function automatic int m_otop();
        return (int'(fl) == 0) ? m_hist[0] : m_s;
    endfunction

    task automatic model_edge();
        int x, otop_pre, fli;
        fli = int'(fl);
        if (rst) begin
            m_hist.delete();
            for (int k = 0; k < SYNC; k++) m_hist.push_back(0);
            m_s = 0; m_run = 0; m_glitch = 0; m_pout = 0; m_poe = 0;
            m_od = 0; m_rise = 0; m_fall = 0;
        end else begin
            x        = m_hist[0];
            otop_pre = (fli == 0) ? x : m_s;
`ifdef IO_PAD_COND_EDGE_EN
            m_rise = (otop_pre == 1 && m_od == 0) ? 1 : 0;
            m_fall = (otop_pre == 0 && m_od == 1) ? 1 : 0;
            m_od   = otop_pre;
`else
            m_rise = 0;
            m_fall = 0;
`endif
            if (fli == 0) begin
                m_s   = x;
                m_run = 0;
            end else if (x != m_s) begin
                if (m_run + 1 >= fli) begin
                    m_s   = x;
                    m_run = 0;
                end else begin
                    m_run++;
                end
            end else if (m_run != 0) begin
                m_run = 0;
                if (m_glitch < GMAX) m_glitch++;
            end
            void'(m_hist.pop_front());
            m_hist.push_back(pad ? 1 : 0);
            m_pout = i_top ? 1 : 0;
            m_poe  = t_top ? 1 : 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic [3:0] fl;
        logic       pad;
        logic       i;
        logic       t;
        logic       e_otop;
        logic       e_pout;
        logic       e_poe;
        logic [7:0] e_g;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input int r, input int f, input int p, input int i, input int t,
                           input int eo, input int ep, input int ee, input int eg);
        vec_t v;
        v.rst = r[0]; v.fl = f[3:0]; v.pad = p[0]; v.i = i[0]; v.t = t[0];
        v.e_otop = eo[0]; v.e_pout = ep[0]; v.e_poe = ee[0]; v.e_g = eg[7:0];
        tbl.push_back(v);
    endtask

    initial begin
        int lat, hold, rose, rise_cnt, fall_cnt, rise_at;

        rst = 1'b1; fl = 4'd0; pad = 1'b1; i_top = 1'b1; t_top = 1'b1;

        //       rst fl pad I  T   otop pout poe glitch
        add_vec(1,  0, 1,  1, 1,  0,   0,   0,  0);   // reset held, pad/T high
        add_vec(1,  0, 1,  1, 1,  0,   0,   0,  0);
        add_vec(1,  0, 1,  1, 1,  0,   0,   0,  0);
        add_vec(0,  0, 0,  1, 1,  0,   1,   1,  0);   // output path n+1
        add_vec(0,  0, 1,  0, 1,  0,   0,   1,  0);   // bypass 1-cycle pulse
        add_vec(0,  0, 0,  1, 0,  1,   1,   0,  0);   // appears 2 cycles later
        add_vec(0,  0, 0,  0, 0,  0,   0,   0,  0);
        add_vec(0,  0, 0,  0, 0,  0,   0,   0,  0);
        add_vec(0,  2, 1,  0, 0,  0,   0,   0,  0);   // filt_len=2, step up
        add_vec(0,  2, 1,  0, 0,  0,   0,   0,  0);
        add_vec(0,  2, 1,  0, 0,  0,   0,   0,  0);
        add_vec(0,  2, 0,  0, 0,  1,   0,   0,  0);   // accepted 4 cycles after step
        add_vec(0,  2, 0,  0, 0,  1,   0,   0,  0);
        add_vec(0,  2, 0,  0, 0,  1,   0,   0,  0);
        add_vec(0,  2, 1,  0, 0,  0,   0,   0,  0);   // fall accepted
        add_vec(0,  2, 0,  0, 0,  0,   0,   0,  0);
        add_vec(0,  2, 0,  0, 0,  0,   0,   0,  0);
        add_vec(0,  2, 0,  0, 0,  0,   0,   0,  1);   // 1-cycle pulse rejected
        add_vec(0,  2, 0,  0, 0,  0,   0,   0,  1);

        #1;
        for (int n = 0; n < tbl.size(); n++) begin
            rst = tbl[n].rst; fl = tbl[n].fl; pad = tbl[n].pad;
            i_top = tbl[n].i; t_top = tbl[n].t;
            tick();
            chk($sformatf("vec%0d_o_top", n),   o_top,   tbl[n].e_otop);
            chk($sformatf("vec%0d_pad_out", n), pad_out, tbl[n].e_pout);
            chk($sformatf("vec%0d_pad_oe", n),  pad_oe,  tbl[n].e_poe);
            chk($sformatf("vec%0d_glitch", n),  glitch,  tbl[n].e_g);
        end

        // Filter accept latency with filt_len=4: SYNC + 4 cycles.
        rst = 1'b1; fl = 4'd4; pad = 1'b0; i_top = 1'b0; t_top = 1'b0;
        tick(); rst = 1'b0;
        repeat (4) tick();
        pad = 1'b1; lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            tick();
            if (o_top) lat = k;
        end
        chk("accept_latency", lat, 6);
        chk("accept_glitch", glitch, 0);

        // Glitch reject: 3-cycle pulses against filt_len=4, then saturation.
        rst = 1'b1; pad = 1'b0; tick(); rst = 1'b0;
        repeat (4) tick();
        rose = 0;
        for (int it = 0; it < 300; it++) begin
            pad = 1'b1;
            repeat (3) begin tick(); if (o_top) rose = 1; end
            pad = 1'b0;
            repeat (4) begin tick(); if (o_top) rose = 1; end
            if (it == 0) chk("glitch_first", glitch, 1);
        end
        chk("glitch_never_accepted", rose, 0);
        chk("glitch_saturated", glitch, 255);

        // Mid-count filt_len drop: count at 5 with filt_len=10, drop to 3.
        rst = 1'b1; fl = 4'd10; pad = 1'b0; tick(); rst = 1'b0;
        repeat (3) tick();
        pad = 1'b1;
        repeat (7) tick();
        chk("midcount_before", o_top, 0);
        fl = 4'd3;
        tick();
        chk("midcount_commit", o_top, 1);
        chk("midcount_glitch", glitch, 0);

        // Reset at count 5 discards the count; full latency afterwards.
        rst = 1'b1; fl = 4'd10; pad = 1'b0; tick(); rst = 1'b0;
        repeat (3) tick();
        pad = 1'b1;
        repeat (7) tick();
        rst = 1'b1; tick();
        chk("midreset_o_top", o_top, 0);
        chk("midreset_glitch", glitch, 0);
        rst = 1'b0; lat = -1;
        for (int k = 1; k <= 30 && lat < 0; k++) begin
            tick();
            if (o_top) lat = k;
        end
        chk("midreset_latency", lat, 12);
        chk("midreset_glitch_after", glitch, 0);

        // Loopback: own driven data reaches O_top through the bypass path.
        rst = 1'b1; fl = 4'd0; pad = 1'b0; tick(); rst = 1'b0;
        i_top = 1'b1; t_top = 1'b1;
        tick();
        chk("loop_pad_out", pad_out, 1);
        chk("loop_pad_oe", pad_oe, 1);
        pad = pad_out;
        repeat (2) tick();
        chk("loop_o_top", o_top, 1);

        // Edge pulses with filt_len=2.
        rst = 1'b1; fl = 4'd2; pad = 1'b0; tick(); rst = 1'b0;
        repeat (4) tick();
        pad = 1'b1; lat = -1; rise_cnt = 0; fall_cnt = 0; rise_at = -1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (o_top && lat < 0) lat = k;
            if (rise) begin rise_cnt++; if (rise_at < 0) rise_at = k; end
            if (fall) fall_cnt++;
        end
        chk("edge_o_top_latency", lat, 4);
        chk("edge_fall_count", fall_cnt, 0);
`ifdef IO_PAD_COND_EDGE_EN
        chk("edge_rise_count", rise_cnt, 1);
        chk("edge_rise_cycle", rise_at, 5);
`else
        chk("edge_rise_count", rise_cnt, 0);
`endif

        // Randomized run against the reference model.
        rst = 1'b1; fl = 4'd3; tick(); rst = 1'b0;
        hold = 0;
        for (int c = 0; c < 2000; c++) begin
            if (hold == 0) begin
                pad  = ~pad;
                hold = int'($urandom_range(1, 8));
            end
            hold--;
            if ($urandom_range(0, 59) == 0) fl = 4'($urandom_range(0, 15));
            i_top = 1'($urandom_range(0, 1));
            t_top = 1'($urandom_range(0, 1));
            rst   = ($urandom_range(0, 399) == 0);
            tick();
            chk("rand_o_top",   o_top,   m_otop());
            chk("rand_pad_out", pad_out, m_pout);
            chk("rand_pad_oe",  pad_oe,  m_poe);
            chk("rand_glitch",  glitch,  m_glitch);
            chk("rand_rise",    rise,    m_rise);
            chk("rand_fall",    fall,    m_fall);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
